muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned multiply/divide unit, one operand bit per cycle
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;
  localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_opnd;   // addend (a) for multiply, divisor (b) for divide
  logic [WIDTH-1:0] r_hi;     // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;     // multiplier bits then product low half / dividend then quotient
  logic [4:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_f;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_result;

  assign w_sum    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {WIDTH{1'b0}})};
  assign w_shift  = {r_hi, r_lo[WIDTH-1]};
  assign w_borrow = (w_shift < {1'b0, r_opnd});
  // The remainder after a successful subtract is always below the divisor, so WIDTH bits suffice.
  assign w_diff   = w_shift[WIDTH-1:0] - r_opnd;

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_op[1]) begin
      w_hi_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_diff;
      w_lo_nxt = {r_lo[WIDTH-2:0], ~w_borrow};
    end else begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Select the requested half / quotient / remainder from the final step
  always_comb begin
    w_result = w_lo_nxt;
    case (r_op)
      OP_MUL:   w_result = w_lo_nxt;
      OP_MULHU: w_result = w_hi_nxt;
      OP_DIVU:  w_result = w_lo_nxt;
      OP_REMU:  w_result = w_hi_nxt;
      default:  w_result = w_lo_nxt;
    endcase
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_f     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start && !flush) begin
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
            r_op    <= op;
            r_cnt   <= 5'd0;
            r_hi    <= '0;
            r_opnd  <= op[1] ? b : a;
            r_lo    <= op[1] ? a : b;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == LAST_CNT) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_f     <= w_result;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign f    = r_f;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] f;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_f;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  // 100 MHz clock
  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .f     (f)
  );

  // Global time limit
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected summary first");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model from plain arithmetic
  function automatic logic [15:0] ref_model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = {16'h0, x} * {16'h0, y};
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (y == 16'h0) ? 16'hFFFF : x / y;
      default: return (y == 16'h0) ? x : x % y;
    endcase
  endfunction

  // Called on the first negedge after the start edge; follows the op to its done pulse
  task automatic wait_done(input logic [15:0] exp, input string nm, input bit jam, input bit hold_start);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    check({nm, "_f_hold"}, {16'h0, f}, {16'h0, last_f});
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) begin
        nb++;
        if (jam) begin
          start = 1'($urandom_range(0, 1));
          a     = 16'($urandom);
          b     = 16'($urandom);
          op    = 2'($urandom);
        end
      end
      @(negedge clk);
    end
    if (!hold_start) start = 1'b0;
    check({nm, "_done_seen"}, {31'h0, seen}, 32'd1);
    check({nm, "_busy_cycles"}, 32'(nb), 32'd16);
    check({nm, "_no_overlap"}, {31'h0, busy}, 32'd0);
    check({nm, "_f"}, {16'h0, f}, {16'h0, exp});
    last_f = exp;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] exp, input string nm, input bit jam);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    op    = 2'($urandom);
    wait_done(exp, nm, jam, 1'b0);
    @(negedge clk);
    check({nm, "_pulse"}, {31'h0, done}, 32'd0);
  endtask

  initial begin
    int nd;
    logic [1:0]  ro;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{2'b00, 16'h0003, 16'h0005, 16'h000F};
    vecs[1] = '{2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE};
    vecs[2] = '{2'b10, 16'd100,  16'd7,    16'h000E};
    vecs[3] = '{2'b11, 16'd100,  16'd7,    16'h0002};
    vecs[4] = '{2'b10, 16'h1234, 16'h0000, 16'hFFFF};
    vecs[5] = '{2'b11, 16'h1234, 16'h0000, 16'h1234};
    vecs[6] = '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0001};
    vecs[7] = '{2'b10, 16'hFFFF, 16'h0001, 16'hFFFF};
    vecs[8] = '{2'b11, 16'h0005, 16'h0009, 16'h0005};
    vecs[9] = '{2'b01, 16'h8000, 16'h0002, 16'h0001};

    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 2'b00;
    a      = 16'h0;
    b      = 16'h0;
    last_f = 16'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_done", {31'h0, done}, 32'd0);
    check("reset_f", {16'h0, f}, 32'h0);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);

    // start and flush together in IDLE
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("sf_idle_busy", {31'h0, busy}, 32'd0);
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("sf_idle_busy2", {31'h0, busy}, 32'd0);

    // Flush at the 5th BUSY cycle
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 16'd3;
    b     = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_pre_busy", {31'h0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'h0, busy}, 32'd0);
    check("flush_done", {31'h0, done}, 32'd0);
    check("flush_f", {16'h0, f}, {16'h0, last_f});
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("flush_no_done", 32'(nd), 32'd0);
    run_op(2'b00, 16'd3, 16'd5, 16'h000F, "after_flush", 1'b0);

    // Back-to-back issue with start held high; operands changed during BUSY
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 16'd3;
    b     = 16'd5;
    @(negedge clk);
    op    = 2'b10;
    a     = 16'd100;
    b     = 16'd7;
    wait_done(16'h000F, "b2b_first", 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_no_idle_busy", {31'h0, busy}, 32'd1);
    check("b2b_no_idle_done", {31'h0, done}, 32'd0);
    start = 1'b0;
    wait_done(16'h000E, "b2b_second", 1'b1, 1'b0);
    @(negedge clk);
    check("b2b_pulse", {31'h0, done}, 32'd0);

    // Flush during DONE suppresses back-to-back start
    @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    a     = 16'd100;
    b     = 16'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(16'h0002, "fl_done", 1'b0, 1'b0);
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("fl_done_busy", {31'h0, busy}, 32'd0);
    check("fl_done_done", {31'h0, done}, 32'd0);

    // Randomized operations against the model
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom);
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = {12'h0, 4'($urandom)};
      run_op(ro, ra, rb, ref_model(ro, ra, rb), $sformatf("rnd%0d", i), 1'(i % 2));
    end

    // Asynchronous reset at BUSY cycle 8
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 16'd3;
    b     = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("rst_pre_busy", {31'h0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_busy", {31'h0, busy}, 32'd0);
    check("rst_async_done", {31'h0, done}, 32'd0);
    check("rst_async_f", {16'h0, f}, 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    last_f = 16'h0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("rst_no_done", 32'(nd), 32'd0);

    // Start accepted on the first edge after reset deassertion
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    op    = 2'b00;
    a     = 16'd3;
    b     = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(16'h000F, "post_rst", 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_pulse", {31'h0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
